score_keeper: RTL and testbench

Sequential score keeper for the two-player tank game. It receives hit events from the collision logic and counts points per player. It sequences rounds with a freeze interval between them and declares a winner. It drives the 6-bit per-player scores consumed by the score/number display renderer, plus round-control strobes for the tank and bullet logic.

---
 rtl/score_pkg.sv | 25 ++
 rtl/score_bcd.sv | 22 ++
 rtl/score_keeper.sv | 185 ++++++++++++++++++
 tb/tb_score_keeper.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// ============================================================================
// Module : score_pkg
// Brief  : Shared types and constants for the tank-game score keeper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int SCORE_W = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        FREEZE    = 2'd2,
        GAME_OVER = 2'd3
    } score_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/score_bcd.sv
// ============================================================================
// Module : score_bcd
// Brief  : Combinational 6-bit binary to two-digit BCD (tens 0..6, ones 0..9).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_bcd
    import score_pkg::*;
(
    input  logic [SCORE_W-1:0] bin_i,
    output logic [3:0]         tens_o,
    output logic [3:0]         ones_o
);

    // Constant divisor on a 6-bit operand reduces to a small lookup.
    assign tens_o = 4'(bin_i / 6'd10);
    assign ones_o = 4'(bin_i % 6'd10);

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module : score_keeper
// Brief  : Per-player scoring, round sequencing with freeze interval and
//          winner detection. Define SCORE_BCD_EN for registered BCD digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE     = 10,
    parameter int FREEZE_FRAMES = 120
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               hit_player_1_i,
    input  logic               hit_player_2_i,
    input  logic               frame_tick_i,
    output logic [SCORE_W-1:0] score_player_1_o,
    output logic [SCORE_W-1:0] score_player_2_o,
    output logic [3:0]         score_1_tens_o,
    output logic [3:0]         score_1_ones_o,
    output logic [3:0]         score_2_tens_o,
    output logic [3:0]         score_2_ones_o,
    output logic               round_active_o,
    output logic               round_restart_o,
    output logic               game_over_o,
    output logic [1:0]         winner_o
);

    localparam logic [SCORE_W-1:0] C_WIN    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         C_FREEZE = 8'(FREEZE_FRAMES);

    score_state_e       r_state;
    logic               r_start_q, r_hit1_q, r_hit2_q;
    logic               r_start_ev, r_hit1_ev, r_hit2_ev;
    logic [7:0]         r_fcnt;
    logic [SCORE_W-1:0] r_score_p1, r_score_p2;
    logic               r_active, r_restart, r_game_over;
    logic [1:0]         r_winner;

    logic               w_clear;
    logic               w_p1_scores, w_p2_scores;
    logic               w_p1_wins, w_p2_wins;
    logic [SCORE_W-1:0] w_p1_next, w_p2_next;
    logic [7:0]         w_fcnt_inc;

    // A hit on one tank awards the point to the other player.
    always_comb begin
        w_clear     = ((r_state == IDLE) || (r_state == GAME_OVER)) && r_start_ev;
        w_p1_scores = (r_state == PLAY) && r_hit2_ev && !r_hit1_ev;
        w_p2_scores = (r_state == PLAY) && r_hit1_ev && !r_hit2_ev;
        w_p1_next   = r_score_p1;
        w_p2_next   = r_score_p2;
        if (w_clear) begin
            w_p1_next = '0;
            w_p2_next = '0;
        end else if (w_p1_scores) begin
            w_p1_next = r_score_p1 + 1'b1;
        end else if (w_p2_scores) begin
            w_p2_next = r_score_p2 + 1'b1;
        end
        w_p1_wins  = w_p1_scores && (w_p1_next == C_WIN);
        w_p2_wins  = w_p2_scores && (w_p2_next == C_WIN);
        w_fcnt_inc = r_fcnt + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_hit1_q    <= 1'b0;
            r_hit2_q    <= 1'b0;
            r_start_ev  <= 1'b0;
            r_hit1_ev   <= 1'b0;
            r_hit2_ev   <= 1'b0;
            r_fcnt      <= '0;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_active    <= 1'b0;
            r_restart   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_start_q  <= start_i;
            r_hit1_q   <= hit_player_1_i;
            r_hit2_q   <= hit_player_2_i;
            r_start_ev <= start_i & ~r_start_q;
            r_hit1_ev  <= hit_player_1_i & ~r_hit1_q;
            r_hit2_ev  <= hit_player_2_i & ~r_hit2_q;
            r_restart  <= 1'b0;
            r_score_p1 <= w_p1_next;
            r_score_p2 <= w_p2_next;
            case (r_state)
                IDLE, GAME_OVER: begin
                    if (w_clear) begin
                        r_state     <= PLAY;
                        r_winner    <= WIN_NONE;
                        r_restart   <= 1'b1;
                        r_active    <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    if (r_hit1_ev || r_hit2_ev) begin
                        r_active <= 1'b0;
                        if (w_p1_wins || w_p2_wins) begin
                            r_state     <= GAME_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= w_p1_wins ? WIN_P1 : WIN_P2;
                        end else begin
                            r_state <= FREEZE;
                            r_fcnt  <= '0;
                        end
                    end
                end
                FREEZE: begin
                    if (frame_tick_i) begin
                        r_fcnt <= w_fcnt_inc;
                        if (w_fcnt_inc == C_FREEZE) begin
                            r_state   <= PLAY;
                            r_restart <= 1'b1;
                            r_active  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_BCD_EN
    logic [3:0] w_t1, w_o1, w_t2, w_o2;
    logic [3:0] r_t1, r_o1, r_t2, r_o2;

    score_bcd u_bcd_p1 (.bin_i(w_p1_next), .tens_o(w_t1), .ones_o(w_o1));
    score_bcd u_bcd_p2 (.bin_i(w_p2_next), .tens_o(w_t2), .ones_o(w_o2));

    // Digits are registered from the next score so they track the binary value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_t1 <= '0;
            r_o1 <= '0;
            r_t2 <= '0;
            r_o2 <= '0;
        end else begin
            r_t1 <= w_t1;
            r_o1 <= w_o1;
            r_t2 <= w_t2;
            r_o2 <= w_o2;
        end
    end

    assign score_1_tens_o = r_t1;
    assign score_1_ones_o = r_o1;
    assign score_2_tens_o = r_t2;
    assign score_2_ones_o = r_o2;
`else
    assign score_1_tens_o = 4'd0;
    assign score_1_ones_o = 4'd0;
    assign score_2_tens_o = 4'd0;
    assign score_2_ones_o = 4'd0;
`endif

    assign score_player_1_o = r_score_p1;
    assign score_player_2_o = r_score_p2;
    assign round_active_o   = r_active;
    assign round_restart_o  = r_restart;
    assign game_over_o      = r_game_over;
    assign winner_o         = r_winner;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ((r_score_p1 <= C_WIN) && (r_score_p2 <= C_WIN))
                else $error("score exceeds WIN_SCORE");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module : tb_score_keeper
// Brief  : Randomised scoreboard bench for score_keeper against a game-rule
//          reference model; honours SCORE_BCD_EN for the digit outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int WIN = 12;
    localparam int FF  = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       hit_player_1_i = 1'b0;
    logic       hit_player_2_i = 1'b0;
    logic       frame_tick_i = 1'b0;
    logic [5:0] score_player_1_o, score_player_2_o;
    logic [3:0] score_1_tens_o, score_1_ones_o, score_2_tens_o, score_2_ones_o;
    logic       round_active_o, round_restart_o, game_over_o;
    logic [1:0] winner_o;

    score_keeper #(.WIN_SCORE(WIN), .FREEZE_FRAMES(FF)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .hit_player_1_i   (hit_player_1_i),
        .hit_player_2_i   (hit_player_2_i),
        .frame_tick_i     (frame_tick_i),
        .score_player_1_o (score_player_1_o),
        .score_player_2_o (score_player_2_o),
        .score_1_tens_o   (score_1_tens_o),
        .score_1_ones_o   (score_1_ones_o),
        .score_2_tens_o   (score_2_tens_o),
        .score_2_ones_o   (score_2_ones_o),
        .round_active_o   (round_active_o),
        .round_restart_o  (round_restart_o),
        .game_over_o      (game_over_o),
        .winner_o         (winner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0] s1;
        logic [5:0] s2;
        logic [3:0] t1;
        logic [3:0] o1;
        logic [3:0] t2;
        logic [3:0] o2;
        logic       active;
        logic       restart;
        logic       over;
        logic [1:0] win;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference game: mode 0 idle, 1 play, 2 freeze, 3 over.
    int m_mode = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_fcnt = 0;
    bit m_restart = 0;
    bit pe_start = 0, pe_h1 = 0, pe_h2 = 0;
    bit lv_start = 0, lv_h1 = 0, lv_h2 = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.s1 = score_player_1_o;  o.s2 = score_player_2_o;
        o.t1 = score_1_tens_o;    o.o1 = score_1_ones_o;
        o.t2 = score_2_tens_o;    o.o2 = score_2_ones_o;
        o.active = round_active_o; o.restart = round_restart_o;
        o.over = game_over_o;     o.win = winner_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.s1 = 6'(m_s1);
        o.s2 = 6'(m_s2);
`ifdef SCORE_BCD_EN
        o.t1 = 4'(m_s1 / 10); o.o1 = 4'(m_s1 % 10);
        o.t2 = 4'(m_s2 / 10); o.o2 = 4'(m_s2 % 10);
`else
        o.t1 = 4'd0; o.o1 = 4'd0; o.t2 = 4'd0; o.o2 = 4'd0;
`endif
        o.active  = (m_mode == 1);
        o.restart = m_restart;
        o.over    = (m_mode == 3);
        o.win     = 2'(m_win);
        return o;
    endfunction

    // Game rules applied to the edges seen one cycle earlier and this cycle's tick.
    task automatic model_step();
        if (!rst_ni) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_fcnt = 0; m_restart = 0;
            pe_start = 0; pe_h1 = 0; pe_h2 = 0;
            lv_start = 0; lv_h1 = 0; lv_h2 = 0;
            return;
        end
        m_restart = 0;
        case (m_mode)
            0, 3: if (pe_start) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_restart = 1; m_mode = 1;
            end
            1: begin
                if (pe_h1 && pe_h2) begin
                    m_mode = 2; m_fcnt = 0;
                end else if (pe_h1) begin
                    m_s2++;
                    if (m_s2 == WIN) begin m_mode = 3; m_win = 2; end
                    else begin m_mode = 2; m_fcnt = 0; end
                end else if (pe_h2) begin
                    m_s1++;
                    if (m_s1 == WIN) begin m_mode = 3; m_win = 1; end
                    else begin m_mode = 2; m_fcnt = 0; end
                end
            end
            2: if (frame_tick_i) begin
                m_fcnt++;
                if (m_fcnt == FF) begin m_mode = 1; m_restart = 1; end
            end
            default: ;
        endcase
        pe_start = start_i && !lv_start;
        pe_h1    = hit_player_1_i && !lv_h1;
        pe_h2    = hit_player_2_i && !lv_h2;
        lv_start = start_i;
        lv_h1    = hit_player_1_i;
        lv_h2    = hit_player_2_i;
    endtask

    task automatic step(input bit r, input bit s, input bit h1, input bit h2, input bit t);
        @(posedge clk_i);
        #2;
        rst_ni         = r;
        start_i        = s;
        hit_player_1_i = h1;
        hit_player_2_i = h2;
        frame_tick_i   = t;
        model_step();
        exp_q.push_back(model_obs());
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual s1=%0d s2=%0d act=%b rst=%b over=%b win=%b dig=%h required s1=%0d s2=%0d act=%b rst=%b over=%b win=%b dig=%h",
                             $time, a.s1, a.s2, a.active, a.restart, a.over, a.win, {a.t1, a.o1, a.t2, a.o2},
                             e.s1, e.s2, e.active, e.restart, e.over, e.win, {e.t1, e.o1, e.t2, e.o2});
                end
            end
        end
    end

    initial begin : driver
        bit ls, l1, l2, tk, found;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            step(1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            step(1, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);

        ls = 0; l1 = 0; l2 = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)  l1 = ~l1;
            if ($urandom_range(0, 5) == 0)  l2 = ~l2;
            if ($urandom_range(0, 19) == 0) ls = ~ls;
            if ($urandom_range(0, 40) == 0) begin l1 = 0; l2 = 0; end
            tk = ($urandom_range(0, 2) == 0);
            step(1, ls, l1, l2, tk);
        end

        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            if (m_mode == 2 && (m_s1 + m_s2) > 0) begin
                found = 1;
            end else begin
                if ($urandom_range(0, 5) == 0)  l1 = ~l1;
                if ($urandom_range(0, 5) == 0)  l2 = ~l2;
                if ($urandom_range(0, 19) == 0) ls = ~ls;
                step(1, ls, l1, l2, 1'b0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL freeze_search: actual no freeze with nonzero score reached, required one within bound");
        end
        step(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (dut_obs() !== '0) begin
            errors++;
            $display("FAIL async_reset: actual %h required 0", dut_obs());
        end
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
